// File: rtl/pad_bus_responder.sv
// +----------------------------------------------------------------------------+
// | pad_bus_responder: pad-side target with word RAM, 64-bit cycle counter and  |
// | FIFO-fed 8N1 serial transmitter.                        Revision: 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module pad_bus_responder #(
    parameter int MEM_ADDR_BITS = 12,
    parameter int TX_FIFO_DEPTH = 4,
    parameter int BAUD_DIV      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pad_address,
    input  logic [31:0] pad_data_in,
    output logic [31:0] pad_data_out,
    input  logic        pad_read,
    input  logic        pad_write,
    input  logic [1:0]  pad_data_size,
    output logic        bus_error,
    output logic        tx,
    output logic        tx_busy
);

    localparam int C_WORDS   = 1 << MEM_ADDR_BITS;
    localparam int C_FIFO_AW = $clog2(TX_FIFO_DEPTH);
    localparam int C_BAUD_W  = $clog2(BAUD_DIV);

    localparam logic [27:0]           C_MMIO_PAGE = 28'hFFF_FFF0;
    localparam logic [C_FIFO_AW:0]    C_PTR_ONE   = 1;
    localparam logic [C_BAUD_W-1:0]   C_BAUD_ONE  = 1;
    localparam logic [C_BAUD_W-1:0]   C_BAUD_LAST = C_BAUD_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ---------------- address decode ----------------
    logic                     w_size_half, w_size_word, w_misaligned;
    logic                     w_ram_hit, w_mmio_hit, w_ok, w_err;
    logic [1:0]               w_reg_sel;
    logic [MEM_ADDR_BITS-1:0] w_word_idx;

    assign w_size_half  = (pad_data_size == 2'b01);
    assign w_size_word  = pad_data_size[1];
    assign w_misaligned = (w_size_half & pad_address[0]) | (w_size_word & (|pad_address[1:0]));
    assign w_ram_hit    = ~(|pad_address[31:MEM_ADDR_BITS+2]);
    assign w_mmio_hit   = (pad_address[31:4] == C_MMIO_PAGE);
    assign w_ok         = ~w_misaligned & (w_ram_hit | w_mmio_hit);
    assign w_err        = (pad_read | pad_write) & ~w_ok;
    assign w_reg_sel    = pad_address[3:2];
    assign w_word_idx   = pad_address[MEM_ADDR_BITS+1:2];

    // ---------------- state ----------------
    logic [31:0]          mem_q [C_WORDS];
    logic [7:0]           fifo_q [TX_FIFO_DEPTH];
    logic [C_FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
    logic                 overflow_q, bus_error_q;
    logic [63:0]          cycle_q;
    logic [31:0]          snap_q;
    state_t               state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [C_BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic                 tx_q, tx_d, busy_q;

    // ---------------- RAM write ----------------
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [4:0]  w_lane_shift;
    logic        w_ram_we;

    assign w_lane_shift = {pad_address[1:0], 3'b000};
    assign w_ram_we     = pad_write & w_ok & w_ram_hit;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        if (w_size_word) begin
            w_be    = 4'b1111;
            w_wdata = pad_data_in;
        end else if (w_size_half) begin
            w_be    = 4'b0011 << pad_address[1:0];
            w_wdata = {16'h0, pad_data_in[15:0]} << w_lane_shift;
        end else begin
            w_be    = 4'b0001 << pad_address[1:0];
            w_wdata = {24'h0, pad_data_in[7:0]} << w_lane_shift;
        end
    end

    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) mem_q[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // ---------------- FIFO ----------------
    logic w_fifo_empty, w_fifo_full, w_push_req, w_push, w_pop;

    assign w_fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign w_fifo_full  = (wr_ptr_q[C_FIFO_AW-1:0] == rd_ptr_q[C_FIFO_AW-1:0]) &
                          (wr_ptr_q[C_FIFO_AW] != rd_ptr_q[C_FIFO_AW]);
    assign w_push_req   = pad_write & w_ok & w_mmio_hit & (w_reg_sel == 2'd0);
    assign w_pop        = (state_q == S_IDLE) & ~w_fifo_empty;
    // A pop frees the slot the push lands in, so a full FIFO still accepts it.
    assign w_push       = w_push_req & (~w_fifo_full | w_pop);

    always_ff @(posedge clock) begin
        if (w_push) fifo_q[wr_ptr_q[C_FIFO_AW-1:0]] <= pad_data_in[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            bus_error_q <= 1'b0;
            cycle_q     <= 64'h0;
            snap_q      <= 32'h0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
            if (w_push_req & w_fifo_full & ~w_pop) overflow_q <= 1'b1;
            bus_error_q <= w_err;
            cycle_q     <= cycle_q + 64'h1;
            if (pad_read & w_ok & w_mmio_hit & (w_reg_sel == 2'd2)) snap_q <= cycle_q[63:32];
        end
    end

    // ---------------- read path ----------------
    logic [31:0] w_rd_word;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;

    always_comb begin
        w_rd_word = 32'h0;
        if (w_ram_hit) begin
            w_rd_word = mem_q[w_word_idx];
        end else if (w_mmio_hit) begin
            case (w_reg_sel)
                2'd1:    w_rd_word = {28'h0, overflow_q, busy_q, w_fifo_full, w_fifo_empty};
                2'd2:    w_rd_word = cycle_q[31:0];
                2'd3:    w_rd_word = snap_q;
                default: w_rd_word = 32'h0;
            endcase
        end

        case (pad_address[1:0])
            2'd0:    w_rd_byte = w_rd_word[7:0];
            2'd1:    w_rd_byte = w_rd_word[15:8];
            2'd2:    w_rd_byte = w_rd_word[23:16];
            default: w_rd_byte = w_rd_word[31:24];
        endcase
        w_rd_half = pad_address[1] ? w_rd_word[31:16] : w_rd_word[15:0];

        pad_data_out = 32'h0;
        if (pad_read & w_ok) begin
            if (w_size_word)      pad_data_out = w_rd_word;
            else if (w_size_half) pad_data_out = {16'h0, w_rd_half};
            else                  pad_data_out = {24'h0, w_rd_byte};
        end
    end

    // ---------------- serializer ----------------
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    shift_d = fifo_q[rd_ptr_q[C_FIFO_AW-1:0]];
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == C_BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + C_BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_q == C_BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + C_BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_q == C_BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + C_BAUD_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Line level is registered from next state so tx never glitches.
        tx_d = (state_d == S_DATA) ? shift_d[0] : (state_d != S_START);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= 8'h0;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign bus_error = bus_error_q;
    assign tx        = tx_q;
    assign tx_busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pad_bus_responder.sv
// +----------------------------------------------------------------------------+
// | tb_pad_bus_responder: vector table, random RAM traffic vs byte-array model, |
// | serial frame and FIFO sequences.                        Revision: 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_pad_bus_responder;

    localparam int MAB       = 8;
    localparam int DEPTH     = 4;
    localparam int BD        = 4;
    localparam int RAM_BYTES = 4 << MAB;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pad_address, pad_data_in, pad_data_out;
    logic        pad_read, pad_write;
    logic [1:0]  pad_data_size;
    logic        bus_error, tx, tx_busy;

    always #5 clock = ~clock;

    pad_bus_responder #(
        .MEM_ADDR_BITS(MAB),
        .TX_FIFO_DEPTH(DEPTH),
        .BAUD_DIV     (BD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pad_address  (pad_address),
        .pad_data_in  (pad_data_in),
        .pad_data_out (pad_data_out),
        .pad_read     (pad_read),
        .pad_write    (pad_write),
        .pad_data_size(pad_data_size),
        .bus_error    (bus_error),
        .tx           (tx),
        .tx_busy      (tx_busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        exp_err_prev = 1'b0;
    int unsigned cyc = 0, rst_cyc = 0;
    logic [7:0]  ram_model [RAM_BYTES];

    // Elapsed clocks since the last edge that sampled reset.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) rst_cyc <= cyc + 1;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] din;
        logic [31:0] dout;
        logic        err;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] d, input logic [31:0] q, input logic e);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.size = sz; v.din = d; v.dout = q; v.err = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] d, input logic [31:0] exp, input logic exp_err,
                         input string name);
        pad_read = rd; pad_write = wr; pad_address = a; pad_data_size = sz; pad_data_in = d;
        @(negedge clock);
        check({name, "_data"}, pad_data_out, rd ? exp : 32'h0);
        check({name, "_buserr"}, bus_error, exp_err_prev);
        exp_err_prev = exp_err;
        @(posedge clock);
        #1;
        pad_read = 1'b0; pad_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
        exp_err_prev = 1'b0;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_bad(input logic [31:0] a, input logic [1:0] sz);
        int n = nbytes(sz);
        return (a >= RAM_BYTES) || ((a % n) != 0);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nbytes(sz); i++) v = v | (32'(ram_model[a + i]) << (8 * i));
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) ram_model[a + i] = 8'(d >> (8 * i));
    endtask

    // Decodes one 8N1 frame by sampling mid-bit on falling clock edges.
    task automatic recv(output logic [7:0] b);
        int t = 0;
        b = 8'h0;
        @(negedge clock);
        while (tx !== 1'b0 && t < 400) begin
            @(negedge clock);
            t++;
        end
        check("rx_start_seen", tx, 1'b0);
        if (tx !== 1'b0) return;
        repeat (BD / 2) @(negedge clock);
        check("rx_start_mid", tx, 1'b0);
        for (int k = 0; k < 8; k++) begin
            repeat (BD) @(negedge clock);
            b[k] = tx;
        end
        repeat (BD) @(negedge clock);
        check("rx_stop_mid", tx, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rxq[$];
        logic [7:0]  sent [6];
        logic [7:0]  rb;
        logic [9:0]  frame;
        logic        rd, wr, bad;
        logic [1:0]  sz;
        logic [31:0] a, d, exp;
        int          lows;

        reset = 1'b1; pad_read = 1'b0; pad_write = 1'b0;
        pad_address = 32'h0; pad_data_in = 32'h0; pad_data_size = 2'b11;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state and counter start value.
        @(negedge clock);
        check("rst_data_out", pad_data_out, 32'h0);
        check("rst_bus_error", bus_error, 1'b0);
        check("rst_tx", tx, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        repeat (100) @(posedge clock);
        #1;
        do_op(1, 0, 32'hFFFF_FF08, 2'b11, 0, 32'd100, 0, "cycle_lo_100");
        idle(7);
        do_op(1, 0, 32'hFFFF_FF08, 2'b11, 0, cyc - rst_cyc, 0, "cycle_lo_live");
        idle(5);
        do_op(1, 0, 32'hFFFF_FF0C, 2'b11, 0, 32'h0, 0, "cycle_hi_snap");

        // Directed vectors.
        add_vec(0, 1, 32'h10, 2'b11, 32'hDEADBEEF, 32'h0, 0);
        add_vec(1, 0, 32'h10, 2'b00, 0, 32'hEF, 0);
        add_vec(1, 0, 32'h11, 2'b00, 0, 32'hBE, 0);
        add_vec(1, 0, 32'h12, 2'b00, 0, 32'hAD, 0);
        add_vec(1, 0, 32'h13, 2'b00, 0, 32'hDE, 0);
        add_vec(1, 0, 32'h12, 2'b01, 0, 32'h0000DEAD, 0);
        add_vec(0, 1, 32'h20, 2'b11, 32'hAAAAAAAA, 32'h0, 0);
        add_vec(0, 1, 32'h22, 2'b01, 32'hFFFF1234, 32'h0, 0);
        add_vec(1, 0, 32'h20, 2'b11, 0, 32'h1234AAAA, 0);
        add_vec(1, 0, 32'h21, 2'b01, 0, 32'h0, 1);
        add_vec(1, 0, 32'h20, 2'b10, 0, 32'h1234AAAA, 0);
        add_vec(0, 1, 32'h22, 2'b11, 32'hFFFFFFFF, 32'h0, 1);
        add_vec(0, 1, 32'h21, 2'b01, 32'hFFFFFFFF, 32'h0, 1);
        add_vec(1, 0, 32'h20, 2'b11, 0, 32'h1234AAAA, 0);
        add_vec(1, 1, 32'h10, 2'b11, 32'h11223344, 32'hDEADBEEF, 0);
        add_vec(1, 0, 32'h10, 2'b11, 0, 32'h11223344, 0);
        add_vec(0, 1, 32'h13, 2'b00, 32'hFFFFFFA5, 32'h0, 0);
        add_vec(1, 0, 32'h10, 2'b11, 0, 32'hA5223344, 0);
        add_vec(1, 0, 32'h400, 2'b11, 0, 32'h0, 1);
        add_vec(0, 1, 32'h400, 2'b11, 32'h55555555, 32'h0, 1);
        add_vec(0, 1, 32'h3FC, 2'b11, 32'hCAFEF00D, 32'h0, 0);
        add_vec(1, 0, 32'h3FE, 2'b01, 0, 32'h0000CAFE, 0);
        add_vec(1, 0, 32'hFFFF_FF04, 2'b11, 0, 32'h1, 0);
        add_vec(1, 0, 32'hFFFF_FF00, 2'b11, 0, 32'h0, 0);
        add_vec(1, 0, 32'hFFFF_FF06, 2'b11, 0, 32'h0, 1);
        add_vec(1, 0, 32'hFFFF_FF10, 2'b11, 0, 32'h0, 1);
        add_vec(0, 1, 32'hFFFF_FF04, 2'b11, 32'hFFFFFFFF, 32'h0, 0);
        add_vec(1, 0, 32'hFFFF_FF04, 2'b00, 0, 32'h1, 0);
        for (int i = 0; i < vecs.size(); i++)
            do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].din,
                  vecs[i].dout, vecs[i].err, $sformatf("vec%0d", i));

        // Fill RAM so every byte the model holds is known.
        for (int w = 0; w < RAM_BYTES / 4; w++) begin
            d = $urandom;
            do_op(0, 1, 32'(w * 4), 2'b11, d, 32'h0, 0, "init");
            model_write(32'(w * 4), 2'b11, d);
        end

        // Random traffic against the byte-array model.
        for (int n = 0; n < 300; n++) begin
            if (n % 25 == 0) begin
                do_op(1, 0, 32'hFFFF_FF08, 2'b11, 0, cyc - rst_cyc, exp_err_prev & 1'b0, "rand_cycle");
            end
            case ($urandom_range(0, 9))
                8:       a = 32'(RAM_BYTES) + 32'($urandom_range(0, 255));
                9:       a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
                default: a = 32'($urandom_range(0, RAM_BYTES - 1));
            endcase
            sz  = 2'($urandom_range(0, 3));
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            d   = $urandom;
            bad = model_bad(a, sz);
            exp = (rd && !bad) ? model_read(a, sz) : 32'h0;
            do_op(rd, wr, a, sz, d, exp, (rd | wr) & bad, "rand");
            if (wr && !bad) model_write(a, sz, d);
        end
        idle(2);

        // Single 0x55 frame, cycle exact.
        frame = {1'b1, 8'h55, 1'b0};
        do_op(0, 1, 32'hFFFF_FF00, 2'b00, 32'h55, 32'h0, 0, "tx55_write");
        @(negedge clock);
        check("tx55_pre_tx", tx, 1'b1);
        check("tx55_pre_busy", tx_busy, 1'b0);
        for (int s = 0; s < 10 * BD; s++) begin
            @(negedge clock);
            check($sformatf("tx55_bit%0d", s / BD), tx, frame[s / BD]);
            check("tx55_busy", tx_busy, 1'b1);
        end
        @(negedge clock);
        check("tx55_post_tx", tx, 1'b1);
        check("tx55_post_busy", tx_busy, 1'b0);
        idle(2);

        // Six back-to-back TXDATA writes: one in flight, four queued, one dropped.
        for (int i = 0; i < 6; i++) sent[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 6; i++)
                    do_op(0, 1, 32'hFFFF_FF00, 2'($urandom_range(0, 3) & 0), {24'hABCDEF, sent[i]},
                          32'h0, 0, "fifo_push");
                do_op(1, 0, 32'hFFFF_FF04, 2'b11, 0, 32'hE, 0, "fifo_status");
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    recv(rb);
                    rxq.push_back(rb);
                end
            end
        join
        check("fifo_rx_count", rxq.size(), 5);
        for (int i = 0; i < rxq.size() && i < 5; i++)
            check($sformatf("fifo_rx_byte%0d", i), rxq[i], sent[i]);
        idle(4 * BD);
        do_op(1, 0, 32'hFFFF_FF04, 2'b11, 0, 32'h9, 0, "status_drained");

        // Reset in the middle of the data bits.
        do_op(0, 1, 32'hFFFF_FF00, 2'b11, 32'hA5, 32'h0, 0, "abort_write");
        lows = 0;
        while (tx !== 1'b0 && lows < 20) begin
            @(negedge clock);
            lows++;
        end
        check("abort_frame_started", tx, 1'b0);
        repeat (3 * BD) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("abort_tx", tx, 1'b1);
        check("abort_busy", tx_busy, 1'b0);
        exp_err_prev = 1'b0;
        @(posedge clock);
        #1;
        do_op(1, 0, 32'hFFFF_FF04, 2'b11, 0, 32'h1, 0, "abort_status");
        do_op(1, 0, 32'hFFFF_FF08, 2'b11, 0, cyc - rst_cyc, 0, "abort_cycle_lo");
        lows = 0;
        for (int s = 0; s < 15 * BD; s++) begin
            @(negedge clock);
            if (tx !== 1'b1) lows++;
        end
        check("abort_no_residual", lows, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
